// File: rtl/cvs_pkg.sv
// cvs_pkg: shared sizing and per-channel configuration type for cvs_channel_gen.
package cvs_pkg;
  localparam int NUM_CH = 5;
  localparam int DIV_W  = 8;

  typedef struct packed {
    logic [DIV_W-1:0] half_period;
    logic [DIV_W-1:0] phase;
  } chan_cfg_t;
endpackage

// File: rtl/cvs_chan_div.sv
// cvs_chan_div: one square-wave channel (phase delay, half-period counter, toggle).
// Define CVS_CHANNEL_GEN_SHADOW_EN to defer running writes to the next toggle edge.
module cvs_chan_div #(
  parameter int DIV_W = cvs_pkg::DIV_W
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             i_run,
  input  logic             i_run_d,
  input  logic             i_wr,
  input  logic [DIV_W-1:0] i_half_period,
  input  logic [DIV_W-1:0] i_phase,
  output logic             o_out,
  output logic             o_pending
);
  import cvs_pkg::*;

  localparam logic [DIV_W-1:0] CNT_ONE = {{(DIV_W-1){1'b0}}, 1'b1};

  logic [DIV_W-1:0] r_h;
  logic [DIV_W-1:0] r_p;
  logic [DIV_W-1:0] r_cnt;
  logic             r_out;
  logic             w_enabled;
  logic             w_apply_now;
  logic             w_sh_take;
  logic             w_sh_idle;
  logic [DIV_W-1:0] w_sh_h;
  logic [DIV_W-1:0] w_sh_p;

  assign w_enabled = (r_h != '0);

`ifdef CVS_CHANNEL_GEN_SHADOW_EN
  logic [DIV_W-1:0] r_sh_h;
  logic [DIV_W-1:0] r_sh_p;
  logic             r_pend;
  logic             w_running;

  // A running, enabled channel parks the write; anything else takes it at once.
  assign w_running   = i_run & i_run_d;
  assign w_apply_now = i_wr & ~(w_running & w_enabled);
  assign w_sh_take   = r_pend & w_running & (r_cnt == '0);
  assign w_sh_idle   = r_pend & ~i_run;
  assign w_sh_h      = r_sh_h;
  assign w_sh_p      = r_sh_p;
  assign o_pending   = r_pend;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_sh_h <= '0;
      r_sh_p <= '0;
      r_pend <= 1'b0;
    end else if (i_wr & w_running & w_enabled) begin
      r_sh_h <= i_half_period;
      r_sh_p <= i_phase;
      r_pend <= 1'b1;
    end else if (w_sh_take | w_sh_idle) begin
      r_pend <= 1'b0;
    end
  end
`else
  assign w_apply_now = i_wr;
  assign w_sh_take   = 1'b0;
  assign w_sh_idle   = 1'b0;
  assign w_sh_h      = '0;
  assign w_sh_p      = '0;
  assign o_pending   = 1'b0;
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_h   <= '0;
      r_p   <= '0;
      r_cnt <= '0;
      r_out <= 1'b0;
    end else if (w_apply_now) begin
      r_h   <= i_half_period;
      r_p   <= i_phase;
      r_out <= 1'b0;
      r_cnt <= (i_run && (i_half_period != '0)) ? i_phase : '0;
    end else if (!w_enabled || !i_run) begin
      r_out <= 1'b0;
      r_cnt <= '0;
      if (w_sh_idle) begin
        r_h <= w_sh_h;
        r_p <= w_sh_p;
      end
    end else if (!i_run_d) begin
      r_cnt <= r_p;
      r_out <= 1'b0;
    end else if (r_cnt == '0) begin
      // A shadowed half-period of 0 switches the channel off instead of toggling.
      if (w_sh_take) begin
        r_h   <= w_sh_h;
        r_p   <= w_sh_p;
        r_out <= (w_sh_h != '0) ? ~r_out : 1'b0;
        r_cnt <= (w_sh_h != '0) ? (w_sh_h - CNT_ONE) : '0;
      end else begin
        r_out <= ~r_out;
        r_cnt <= r_h - CNT_ONE;
      end
    end else begin
      r_cnt <= r_cnt - CNT_ONE;
    end
  end

  assign o_out = r_out;
endmodule

// File: rtl/cvs_channel_gen.sv
// cvs_channel_gen: NUM_CH independent square-wave drive channels for simple_fpga_cvs.
// Optional CVS_CHANNEL_GEN_SHADOW_EN makes running reconfiguration take effect on a toggle.
module cvs_channel_gen #(
  parameter int NUM_CH = cvs_pkg::NUM_CH,
  parameter int DIV_W  = cvs_pkg::DIV_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              run,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [2:0]        cfg_ch,
  input  logic [DIV_W-1:0]  cfg_half_period,
  input  logic [DIV_W-1:0]  cfg_phase,
  output logic [NUM_CH-1:0] out,
  output logic              cfg_err
);
  import cvs_pkg::*;

  logic              r_run_d;
  logic              r_rdy;
  logic              r_err;
  logic              w_accept;
  logic [NUM_CH-1:0] w_wr;
  logic [NUM_CH-1:0] w_pend;

  assign w_accept  = cfg_valid & cfg_ready;
  assign cfg_ready = r_rdy & ~(|w_pend);
  assign cfg_err   = r_err;

  // r_run_d low after reset makes the first run-high edge a start edge.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_run_d <= 1'b0;
      r_rdy   <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_run_d <= run;
      r_rdy   <= 1'b1;
      if (w_accept && (int'(cfg_ch) >= NUM_CH)) r_err <= 1'b1;
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    assign w_wr[i] = w_accept && (int'(cfg_ch) == i);

    cvs_chan_div #(
      .DIV_W(DIV_W)
    ) u_ch (
      .clock         (clock),
      .reset         (reset),
      .i_run         (run),
      .i_run_d       (r_run_d),
      .i_wr          (w_wr[i]),
      .i_half_period (cfg_half_period),
      .i_phase       (cfg_phase),
      .o_out         (out[i]),
      .o_pending     (w_pend[i])
    );
  end
endmodule

// File: tb/tb_cvs_channel_gen.sv
// Bench for cvs_channel_gen: toggle-time reference model plus directed and random scenarios.
module tb_cvs_channel_gen;
  import cvs_pkg::*;

  logic              clock = 1'b0;
  logic              reset;
  logic              run;
  logic              cfg_valid;
  logic              cfg_ready;
  logic [2:0]        cfg_ch;
  logic [DIV_W-1:0]  cfg_half_period;
  logic [DIV_W-1:0]  cfg_phase;
  logic [NUM_CH-1:0] out;
  logic              cfg_err;

  always #5 clock = ~clock;

  cvs_channel_gen #(.NUM_CH(NUM_CH), .DIV_W(DIV_W)) dut (
    .clock(clock), .reset(reset), .run(run), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_ch(cfg_ch), .cfg_half_period(cfg_half_period), .cfg_phase(cfg_phase),
    .out(out), .cfg_err(cfg_err)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int k = 0;

  // Model: each live channel toggles at edges f, f+H, f+2H, ... starting from value v0.
  chan_cfg_t m_cfg [NUM_CH];
  chan_cfg_t m_sh  [NUM_CH];
  bit        m_pend[NUM_CH];
  bit        m_live[NUM_CH];
  bit        m_v0  [NUM_CH];
  int        m_f   [NUM_CH];
  bit        m_rdy, m_err, m_run_prev;

  function automatic bit mdl_out(int c, int e);
    int h;
    h = int'(m_cfg[c].half_period);
    if (!m_live[c] || h == 0) return 1'b0;
    if (e < m_f[c]) return m_v0[c];
    return m_v0[c] ^ ((((e - m_f[c]) / h) % 2) == 0);
  endfunction

  function automatic bit mdl_tog(int c, int e);
    int h;
    h = int'(m_cfg[c].half_period);
    return m_live[c] && h != 0 && e >= m_f[c] && ((e - m_f[c]) % h) == 0;
  endfunction

  function automatic logic [NUM_CH-1:0] mdl_vec();
    logic [NUM_CH-1:0] v;
    v = '0;
    for (int c = 0; c < NUM_CH; c++) v[c] = mdl_out(c, k);
    return v;
  endfunction

  function automatic bit mdl_ready();
    bit any;
    any = 1'b0;
    for (int c = 0; c < NUM_CH; c++) any |= m_pend[c];
    return m_rdy && !any;
  endfunction

  task automatic model_reset();
    for (int c = 0; c < NUM_CH; c++) begin
      m_cfg[c] = '0; m_sh[c] = '0; m_pend[c] = 0; m_live[c] = 0; m_v0[c] = 0; m_f[c] = 0;
    end
    m_rdy = 0; m_err = 0; m_run_prev = 0;
  endtask

  task automatic start_chan(int c, int e);
    m_live[c] = (m_cfg[c].half_period != 0);
    m_v0[c]   = 1'b0;
    m_f[c]    = e + int'(m_cfg[c].phase) + 1;
  endtask

  task automatic model_edge(bit r, bit v, int ch, int h, int p);
    bit acc;
    bit cur;
    acc = v && mdl_ready();
    if (acc && ch >= NUM_CH) m_err = 1'b1;
    for (int c = 0; c < NUM_CH; c++) begin
`ifdef CVS_CHANNEL_GEN_SHADOW_EN
      if (m_pend[c] && r && m_run_prev && mdl_tog(c, k)) begin
        cur = mdl_out(c, k);
        m_cfg[c] = m_sh[c]; m_pend[c] = 0;
        m_live[c] = (m_cfg[c].half_period != 0);
        m_v0[c] = cur;
        m_f[c] = k + int'(m_cfg[c].half_period);
      end else
`endif
      if (acc && ch == c) begin
`ifdef CVS_CHANNEL_GEN_SHADOW_EN
        if (r && m_run_prev && m_cfg[c].half_period != 0) begin
          m_pend[c] = 1; m_sh[c].half_period = h[DIV_W-1:0]; m_sh[c].phase = p[DIV_W-1:0];
        end else
`endif
        begin
          m_cfg[c].half_period = h[DIV_W-1:0]; m_cfg[c].phase = p[DIV_W-1:0];
          if (r) start_chan(c, k); else m_live[c] = 0;
        end
      end else if (!r) begin
        m_live[c] = 0;
        if (m_pend[c]) begin m_cfg[c] = m_sh[c]; m_pend[c] = 0; end
      end else if (!m_run_prev) begin
        start_chan(c, k);
      end
    end
    m_run_prev = r;
    m_rdy = 1'b1;
  endtask

  task automatic cyc(bit r, bit v, int ch, int h, int p);
    run = r; cfg_valid = v; cfg_ch = 3'(ch);
    cfg_half_period = DIV_W'(h); cfg_phase = DIV_W'(p);
    @(posedge clock);
    k++;
    model_edge(r, v, ch, h, p);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; run = 0; cfg_valid = 0; cfg_ch = 0; cfg_half_period = 0; cfg_phase = 0;
    model_reset();
    repeat (2) @(posedge clock);
    #1;
    n_cmp++; if (out !== '0) begin n_bad++; $display("FAIL reset_out: got %b want 0", out); end
    n_cmp++; if (cfg_ready !== 1'b0) begin n_bad++; $display("FAIL reset_ready: got %b want 0", cfg_ready); end
    n_cmp++; if (cfg_err !== 1'b0) begin n_bad++; $display("FAIL reset_err: got %b want 0", cfg_err); end
    #2 reset = 1'b0;
    cyc(0, 0, 0, 0, 0);
    n_cmp++; if (cfg_ready !== 1'b1) begin n_bad++; $display("FAIL ready_after_reset: got %b want 1", cfg_ready); end
  endtask

  task automatic test_h1p0();
    cyc(0, 1, 0, 1, 0);
    cyc(0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0);
    n_cmp++; if (out[0] !== 1'b0) begin n_bad++; $display("FAIL h1_start: got %b want 0", out[0]); end
    for (int d = 1; d <= 6; d++) begin
      cyc(1, 0, 0, 0, 0);
      n_cmp++; if (out[0] !== 1'(d % 2)) begin n_bad++; $display("FAIL h1_toggle d=%0d: got %b want %b", d, out[0], d % 2); end
      n_cmp++; if (out !== mdl_vec()) begin n_bad++; $display("FAIL h1_model d=%0d: got %b want %b", d, out, mdl_vec()); end
    end
    cyc(0, 0, 0, 0, 0);
    n_cmp++; if (out !== '0) begin n_bad++; $display("FAIL h1_stop: got %b want 0", out); end
  endtask

  task automatic run_ch2_pattern(string tag, int last);
    bit want;
    for (int d = 0; d <= last; d++) begin
      cyc(1, 0, 0, 0, 0);
      want = (d < 3) ? 1'b0 : ((((d - 3) / 3) % 2) == 0);
      n_cmp++; if (out[2] !== want) begin n_bad++; $display("FAIL %s d=%0d: got %b want %b", tag, d, out[2], want); end
      n_cmp++; if (out !== mdl_vec()) begin n_bad++; $display("FAIL %s_model d=%0d: got %b want %b", tag, d, out, mdl_vec()); end
    end
  endtask

  task automatic test_ch2_phase();
    cyc(0, 1, 2, 3, 2);
    cyc(0, 0, 0, 0, 0);
    run_ch2_pattern("ch2_phase", 12);
  endtask

  task automatic test_bad_ch();
    logic [NUM_CH-1:0] want;
    cyc(1, 1, 5, 7, 7);
    want = mdl_vec();
    n_cmp++; if (cfg_err !== 1'b1) begin n_bad++; $display("FAIL bad_ch_err: got %b want 1", cfg_err); end
    n_cmp++; if (out !== want) begin n_bad++; $display("FAIL bad_ch_out: got %b want %b", out, want); end
    for (int i = 0; i < 5; i++) begin
      cyc(1, 0, 0, 0, 0);
      n_cmp++; if (out !== mdl_vec()) begin n_bad++; $display("FAIL bad_ch_run: got %b want %b", out, mdl_vec()); end
    end
    n_cmp++; if (cfg_err !== 1'b1) begin n_bad++; $display("FAIL bad_ch_sticky: got %b want 1", cfg_err); end
  endtask

  task automatic test_run_drop();
    cyc(1, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    n_cmp++; if (out !== '0) begin n_bad++; $display("FAIL drop_out: got %b want 0", out); end
    cyc(0, 0, 0, 0, 0);
    run_ch2_pattern("restart", 8);
  endtask

  task automatic test_update();
    cyc(0, 0, 0, 0, 0);
    cyc(0, 1, 1, 4, 0);
    cyc(1, 0, 0, 0, 0);
    for (int d = 1; d <= 12; d++) begin
      if (d == 3) cyc(1, 1, 1, 2, 0); else cyc(1, 0, 0, 0, 0);
      n_cmp++; if (out !== mdl_vec()) begin n_bad++; $display("FAIL upd_model d=%0d: got %b want %b", d, out, mdl_vec()); end
      n_cmp++; if (cfg_ready !== mdl_ready()) begin n_bad++; $display("FAIL upd_ready d=%0d: got %b want %b", d, cfg_ready, mdl_ready()); end
`ifdef CVS_CHANNEL_GEN_SHADOW_EN
      // toggles at d=1,5 (H=4); new H=2 lands on d=5, so later toggles at 7,9,11
      if (d == 3 || d == 4) begin
        n_cmp++; if (cfg_ready !== 1'b0) begin n_bad++; $display("FAIL upd_pending d=%0d: got %b want 0", d, cfg_ready); end
      end
      if (d >= 5) begin
        n_cmp++; if (out[1] !== ((((d - 5) / 2) % 2) == 0 ? 1'b0 : 1'b1)) begin
          n_bad++; $display("FAIL upd_half2 d=%0d: got %b", d, out[1]);
        end
      end
`else
      // restart at d=3 (out 0), then toggles at 4,6,8,...
      if (d >= 3) begin
        n_cmp++; if (out[1] !== ((d == 3) ? 1'b0 : ((((d - 4) / 2) % 2) == 0))) begin
          n_bad++; $display("FAIL upd_restart d=%0d: got %b", d, out[1]);
        end
      end
`endif
    end
    n_cmp++; if (cfg_ready !== 1'b1) begin n_bad++; $display("FAIL upd_ready_end: got %b want 1", cfg_ready); end
  endtask

  task automatic test_max_h();
    cyc(0, 0, 0, 0, 0);
    cyc(0, 1, 3, 255, 0);
    cyc(1, 0, 0, 0, 0);
    for (int d = 1; d <= 520; d++) begin
      cyc(1, 0, 0, 0, 0);
      n_cmp++; if (out !== mdl_vec()) begin n_bad++; $display("FAIL maxh_model d=%0d: got %b want %b", d, out, mdl_vec()); end
      if (d == 1 || d == 255 || d == 256 || d == 510) begin
        n_cmp++; if (out[3] !== (d < 256)) begin n_bad++; $display("FAIL maxh_edge d=%0d: got %b want %b", d, out[3], d < 256); end
      end
    end
  endtask

  task automatic test_random();
    bit r;
    bit v;
    r = 1'b1;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 19) == 0) r = ~r;
      v = ($urandom_range(0, 5) == 0);
      cyc(r, v, $urandom_range(0, 7), $urandom_range(0, 6), $urandom_range(0, 7));
      n_cmp++; if (out !== mdl_vec()) begin n_bad++; $display("FAIL rnd_out i=%0d: got %b want %b", i, out, mdl_vec()); end
      n_cmp++; if (cfg_ready !== mdl_ready()) begin n_bad++; $display("FAIL rnd_ready i=%0d: got %b want %b", i, cfg_ready, mdl_ready()); end
      n_cmp++; if (cfg_err !== m_err) begin n_bad++; $display("FAIL rnd_err i=%0d: got %b want %b", i, cfg_err, m_err); end
    end
  endtask

  task automatic test_reset_mid();
    cyc(0, 0, 0, 0, 0);
    for (int c = 0; c < NUM_CH; c++) cyc(0, 1, c, c + 1, c);
    for (int i = 0; i < 12; i++) cyc(1, 0, 0, 0, 0);
    n_cmp++; if (out !== mdl_vec()) begin n_bad++; $display("FAIL pre_reset: got %b want %b", out, mdl_vec()); end
    reset = 1'b1;
    model_reset();
    #1;
    n_cmp++; if (out !== '0) begin n_bad++; $display("FAIL async_reset_out: got %b want 0", out); end
    n_cmp++; if (cfg_ready !== 1'b0) begin n_bad++; $display("FAIL async_reset_ready: got %b want 0", cfg_ready); end
    n_cmp++; if (cfg_err !== 1'b0) begin n_bad++; $display("FAIL async_reset_err: got %b want 0", cfg_err); end
    @(posedge clock);
    #2 reset = 1'b0;
    cyc(1, 0, 0, 0, 0);
    n_cmp++; if (cfg_ready !== 1'b1) begin n_bad++; $display("FAIL release_ready: got %b want 1", cfg_ready); end
    for (int i = 0; i < 8; i++) begin
      cyc(1, 0, 0, 0, 0);
      n_cmp++; if (out !== '0) begin n_bad++; $display("FAIL release_out: got %b want 0", out); end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_h1p0();
    test_ch2_phase();
    test_bad_ch();
    test_run_drop();
    test_update();
    test_max_h();
    test_random();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
